// File: rtl/tick_gen_multi.sv
// tick_gen_multi: per-channel programmable clock-enable divider with a one-cycle tick and an alive flag.
// Define TICKGEN_RUNTIME_CFG_EN to enable runtime period writes (shadow/active periods, cfg_err).
module tick_gen_multi #(
  parameter int          CHANNELS    = 2,
  parameter int          SEL_WIDTH   = 1,
  parameter int          CNT_WIDTH   = 32,
  parameter int unsigned DEFAULT_MAX = 32'd50000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CHANNELS-1:0]  enable,
  input  logic [CHANNELS-1:0]  mode,
  input  logic                 restart,
  input  logic                 cfg_we,
  input  logic [SEL_WIDTH-1:0] cfg_sel,
  input  logic [CNT_WIDTH-1:0] cfg_data,
  output logic [CHANNELS-1:0]  tick,
  output logic [CHANNELS-1:0]  flag,
  output logic                 cfg_err
);
  localparam logic [CNT_WIDTH-1:0] RESET_MAX = CNT_WIDTH'(DEFAULT_MAX);
  localparam logic [CNT_WIDTH-1:0] ONE       = CNT_WIDTH'(1);

`ifdef TICKGEN_RUNTIME_CFG_EN
  localparam logic [SEL_WIDTH:0] SEL_LIMIT = (SEL_WIDTH+1)'(CHANNELS);
  logic cfg_ok;

  assign cfg_ok = (cfg_data != '0) && ({1'b0, cfg_sel} < SEL_LIMIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cfg_err <= 1'b0;
    else        cfg_err <= cfg_we && !cfg_ok;
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{cfg_we, cfg_sel, cfg_data};
  assign cfg_err    = 1'b0;
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] active_max;
    logic                 tick_q;
    logic                 flag_q;
    logic                 wrap;
    logic                 load_now;

    // A period of 0 or 1 degenerates to a tick every enabled cycle.
    assign wrap = (active_max <= ONE) || (cnt == active_max - ONE);

`ifdef TICKGEN_RUNTIME_CFG_EN
    logic [CNT_WIDTH-1:0] shadow_max;
    logic                 wr_hit;

    assign wr_hit   = cfg_we && cfg_ok && (cfg_sel == SEL_WIDTH'(i));
    // An idle channel takes a new period at once and restarts its phase.
    assign load_now = !restart && !enable[i] && (wr_hit || (shadow_max != active_max));

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        active_max <= RESET_MAX;
        shadow_max <= RESET_MAX;
      end else begin
        if (wr_hit) shadow_max <= cfg_data;
        if (restart) begin
          if (wr_hit) active_max <= cfg_data;
        end else if (enable[i]) begin
          if (wrap) active_max <= wr_hit ? cfg_data : shadow_max;
        end else begin
          active_max <= wr_hit ? cfg_data : shadow_max;
        end
      end
    end
`else
    assign active_max = RESET_MAX;
    assign load_now   = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt    <= '0;
        tick_q <= 1'b0;
        flag_q <= 1'b0;
      end else if (restart) begin
        cnt    <= '0;
        tick_q <= 1'b0;
        flag_q <= 1'b0;
      end else if (enable[i]) begin
        tick_q <= wrap;
        cnt    <= wrap ? '0 : cnt + ONE;
        if (!mode[i])  flag_q <= 1'b0;
        else if (wrap) flag_q <= ~flag_q;
      end else begin
        tick_q <= 1'b0;
        if (load_now) cnt <= '0;
      end
    end

    assign tick[i] = tick_q;
    assign flag[i] = flag_q;
  end

endmodule
